// File: rtl/addsub_pkg.sv
// Shared definitions for the bit-serial add/subtract unit: FSM encoding,
// counter sizing and the saturation constant builders used when
// SERIAL_ADDSUB_SAT_EN is defined.
package addsub_pkg;

    // Control FSM encoding; also visible on the debug state output.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Saturation builders produce words up to this width.
    localparam int SAT_WORD_W = 64;

    // Bits needed to count 0 .. value-1 (at least one bit).
    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                r = i + 1;
            end
        end
        if (r == 0) begin
            r = 1;
        end
        return r;
    endfunction

    // Largest positive two's-complement value of the given width: 0111..1
    function automatic logic [SAT_WORD_W-1:0] sat_pos_word(input int width);
        return (SAT_WORD_W'(1) << (width - 1)) - SAT_WORD_W'(1);
    endfunction

    // Most negative two's-complement value of the given width: 1000..0
    function automatic logic [SAT_WORD_W-1:0] sat_neg_word(input int width);
        return SAT_WORD_W'(1) << (width - 1);
    endfunction

endpackage

// File: rtl/serial_addsub_unit_fa_bit.sv
// One-bit full adder assembled from two half adders with the two half-adder
// carries ORed together. The serial unit instantiates exactly one of these.

// Half adder cell: sum and carry of two bits.
module half_adder (
    input  logic a,
    input  logic b,
    output logic s,
    output logic c
);
    assign s = a ^ b;
    assign c = a & b;
endmodule

// Full adder: first half adder combines a and b, second adds carry-in.
module fa_bit (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);
    logic s0;
    logic c0;
    logic c1;

    half_adder u_ha0 (
        .a (a),
        .b (b),
        .s (s0),
        .c (c0)
    );

    half_adder u_ha1 (
        .a (s0),
        .b (cin),
        .s (s),
        .c (c1)
    );

    // The two carries can never both be 1, so OR equals majority(a,b,cin).
    assign cout = c0 | c1;
endmodule

// File: rtl/serial_addsub_unit.sv
// Bit-serial two's-complement add/subtract unit. One bit per clock through a
// single full-adder cell; WIDTH cycles from operand accept to result valid.
// Optional feature macro: SERIAL_ADDSUB_SAT_EN (saturate o_sum on signed
// overflow). Without it the result wraps modulo 2^WIDTH.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high. o_ready is a pure decode of the registered state (high only in
// IDLE); o_valid is a pure decode of DONE. Neither depends combinationally
// on i_valid or i_ready. Results hold stable in DONE until accepted.
module serial_addsub_unit
    import addsub_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [WIDTH-1:0] i_A,
    input  logic [WIDTH-1:0] i_B,
    input  logic             i_sub,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [WIDTH-1:0] o_sum,
    output logic             o_carry,
    output logic             o_overflow,
    output logic [1:0]       o_state
);

    localparam int CNT_W = clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

`ifdef SERIAL_ADDSUB_SAT_EN
    localparam logic [WIDTH-1:0] SAT_POS = WIDTH'(sat_pos_word(WIDTH));
    localparam logic [WIDTH-1:0] SAT_NEG = WIDTH'(sat_neg_word(WIDTH));
`endif

    state_t            state_q;
    state_t            state_d;

    logic [WIDTH-1:0]  a_q;      // operand A, consumed from bit 0
    logic [WIDTH-1:0]  b_q;      // operand B (inverted for subtract)
    logic              c_q;      // running carry between bit slices
    logic [WIDTH-1:0]  res_q;    // partial result, filled from the MSB side
    logic [CNT_W-1:0]  cnt_q;    // index of the bit processed next

    logic [WIDTH-1:0]  sum_q;
    logic              carry_q;
    logic              ovf_q;

    logic              accept;
    logic              last_bit;
    logic              fa_sum;
    logic              fa_cout;
    logic              ovf_now;
    logic [WIDTH-1:0]  wrap_sum;
    logic [WIDTH-1:0]  final_sum;

    // Single full-adder cell shared by every bit position.
    fa_bit u_fa (
        .a    (a_q[0]),
        .b    (b_q[0]),
        .cin  (c_q),
        .s    (fa_sum),
        .cout (fa_cout)
    );

    assign accept   = (state_q == IDLE) && i_valid;
    assign last_bit = (state_q == SHIFT) && (cnt_q == LAST_BIT);

    // On the MSB slice c_q is the carry into the MSB and fa_cout the carry out.
    assign ovf_now  = c_q ^ fa_cout;
    assign wrap_sum = {fa_sum, res_q[WIDTH-1:1]};

`ifdef SERIAL_ADDSUB_SAT_EN
    // Saturate toward the sign of A; a_q[0] holds A's MSB on the last slice.
    always_comb begin
        final_sum = wrap_sum;
        if (ovf_now) begin
            final_sum = a_q[0] ? SAT_NEG : SAT_POS;
        end
    end
`else
    assign final_sum = wrap_sum;
`endif

    // State register.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: IDLE -> SHIFT -> DONE -> IDLE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (i_valid) begin
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (cnt_q == LAST_BIT) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (i_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Operand capture, serial datapath and result registers.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            a_q     <= '0;
            b_q     <= '0;
            c_q     <= 1'b0;
            res_q   <= '0;
            cnt_q   <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            if (accept) begin
                // A - B is computed as A + ~B + 1.
                a_q   <= i_A;
                b_q   <= i_B ^ {WIDTH{i_sub}};
                c_q   <= i_sub;
                cnt_q <= '0;
            end else if (state_q == SHIFT) begin
                a_q   <= a_q >> 1;
                b_q   <= b_q >> 1;
                c_q   <= fa_cout;
                res_q <= wrap_sum;
                cnt_q <= cnt_q + CNT_W'(1);
                if (last_bit) begin
                    sum_q   <= final_sum;
                    carry_q <= fa_cout;
                    ovf_q   <= ovf_now;
                end
            end
        end
    end

    assign o_ready    = (state_q == IDLE);
    assign o_valid    = (state_q == DONE);
    assign o_sum      = sum_q;
    assign o_carry    = carry_q;
    assign o_overflow = ovf_q;
    assign o_state    = state_q;

endmodule
